mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 36 +++
 rtl/mux_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module : mux_arb_pkg
// Brief  : Shared types and constants for the round-robin mux-select arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_GRANT = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; first set request at or above
//          the pointer (mod NUM_REQ) wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_rr_ptr,
    output logic [SEL_W-1:0]   o_winner,
    output logic               o_found
);

    logic [SEL_W-1:0] w_idx;

    // Scan from the far end down so the closest request to the pointer wins last.
    always_comb begin
        o_winner = i_rr_ptr;
        o_found  = 1'b0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = i_rr_ptr + SEL_W'(i);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_found  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module : mux_rr_arbiter
// Brief  : Round-robin owner arbiter driving 4:1 mux selects with
//          break-before-make guard cycles and hold-time preemption.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX     = 8,
    parameter int GUARD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               select0,
    output logic               select1,
    output logic               mux_oe,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);

    localparam logic [7:0] c_hold_max    = 8'(HOLD_MAX);
    localparam logic [7:0] c_hold_last   = 8'(HOLD_MAX - 1);
    localparam logic [3:0] c_guard_init  = 4'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
    localparam logic       c_guard_skip  = (GUARD_CYCLES == 0);

    arb_state_t         r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [7:0]         r_hold_cnt;
    logic [3:0]         r_guard_cnt;
    logic               r_mux_oe;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;

    arb_state_t         w_state_nx;
    logic [SEL_W-1:0]   w_sel_nx;
    logic [SEL_W-1:0]   w_rr_ptr_nx;
    logic [7:0]         w_hold_nx;
    logic [3:0]         w_guard_nx;
    logic               w_launch;
    logic               w_owner_req;
    logic               w_others;
    logic [SEL_W-1:0]   w_pick_ptr;
    logic [SEL_W-1:0]   w_winner;
    logic               w_found;

    // While granting, the next arbitration already starts just past the owner.
    assign w_pick_ptr  = (r_state == ST_GRANT) ? SEL_W'(r_sel + 1'b1) : r_rr_ptr;
    assign w_owner_req = req[r_sel];
    assign w_others    = |(req & ~sel_onehot(r_sel));

    rr_pick u_rr_pick (
        .i_req    (req),
        .i_rr_ptr (w_pick_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_rr_ptr_nx = r_rr_ptr;
        w_hold_nx   = r_hold_cnt;
        w_guard_nx  = r_guard_cnt;
        w_launch    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_launch = w_found;
            end
            ST_GUARD: begin
                if (r_guard_cnt == 4'd0) begin
                    w_state_nx = ST_GRANT;
                    w_hold_nx  = 8'd0;
                end else begin
                    w_guard_nx = r_guard_cnt - 4'd1;
                end
            end
            ST_GRANT: begin
                // A late-arriving waiter after saturation preempts at once.
                if (!w_owner_req || (w_others && (r_hold_cnt >= c_hold_last))) begin
                    w_rr_ptr_nx = SEL_W'(r_sel + 1'b1);
                    if (w_found) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_hold_nx  = 8'd0;
                    end
                end else if (r_hold_cnt != c_hold_max) begin
                    w_hold_nx = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_launch) begin
            w_sel_nx = w_winner;
            if (c_guard_skip) begin
                w_state_nx = ST_GRANT;
                w_hold_nx  = 8'd0;
            end else begin
                w_state_nx = ST_GUARD;
                w_guard_nx = c_guard_init;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= 8'd0;
            r_guard_cnt <= 4'd0;
            r_mux_oe    <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sel       <= w_sel_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_hold_cnt  <= w_hold_nx;
            r_guard_cnt <= w_guard_nx;
            r_mux_oe    <= (w_state_nx == ST_GRANT);
            r_grant     <= (w_state_nx == ST_GRANT) ? sel_onehot(w_sel_nx) : '0;
            r_busy      <= (w_state_nx != ST_IDLE);
        end
    end

    assign select0 = r_sel[0];
    assign select1 = r_sel[1];
    assign mux_oe  = r_mux_oe;
    assign grant   = r_grant;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module : tb_mux_rr_arbiter
// Brief  : Self-checking bench for mux_rr_arbiter with reference owner model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int HM = 8;
    localparam int GC = 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       select0;
    logic       select1;
    logic       mux_oe;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] din;

    wire        y_nand;
    wire        y_tri;
    wire  [8:0] dut_vec;

    int errors;
    int checks;

    // Reference model: phase 0 idle, 1 guard, 2 grant.
    int m_phase;
    int m_sel;
    int m_ptr;
    int m_guard_left;
    int m_held;

    mux_rr_arbiter #(
        .HOLD_MAX     (HM),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .select0 (select0),
        .select1 (select1),
        .mux_oe  (mux_oe),
        .grant   (grant),
        .busy    (busy)
    );

    assign y_nand = ~(~(din[0] & ~select1 & ~select0) & ~(din[1] & ~select1 & select0) &
                      ~(din[2] &  select1 & ~select0) & ~(din[3] &  select1 & select0));
    assign y_tri  = mux_oe ? din[{select1, select0}] : 1'bz;
    assign dut_vec = {select1, select0, mux_oe, busy, grant};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model_vec();
        logic [3:0] g;
        g = (m_phase == 2) ? 4'(1 << m_sel) : 4'b0000;
        return {2'(m_sel), (m_phase == 2), (m_phase != 0), g};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_ptr = 0; m_guard_left = 0; m_held = 0;
    endtask

    task automatic model_start(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(m_ptr + i) % 4]) begin
                m_sel = (m_ptr + i) % 4;
                break;
            end
        end
        if (GC == 0) begin
            m_phase = 2; m_held = 0;
        end else begin
            m_phase = 1; m_guard_left = GC;
        end
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic others;
        case (m_phase)
            0: if (r != 4'b0) model_start(r);
            1: begin
                m_guard_left--;
                if (m_guard_left == 0) begin
                    m_phase = 2; m_held = 0;
                end
            end
            default: begin
                m_held++;
                others = (r & ~4'(1 << m_sel)) != 4'b0;
                if (!r[m_sel] || (others && m_held >= HM)) begin
                    m_ptr = (m_sel + 1) % 4;
                    if (r != 4'b0) model_start(r);
                    else m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic tick(input logic [3:0] r);
        req = r;
        din = 4'($urandom);
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", dut_vec, 9'b0);
        end
        rst_n = 1'b1;
        model_reset();
        tick(4'b0000);
        checks++;
        if (dut_vec !== 9'b0) begin
            errors++;
            $display("FAIL idle_no_req: got %b want %b", dut_vec, 9'b0);
        end
    endtask

    task automatic test_single_request();
        do_reset();
        tick(4'b0100);
        checks++;
        if (dut_vec !== {2'b10, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL single_guard: got %b want %b", dut_vec, {2'b10, 1'b0, 1'b1, 4'b0000});
        end
        tick(4'b0100);
        checks++;
        if (dut_vec !== {2'b10, 1'b1, 1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL single_grant: got %b want %b", dut_vec, {2'b10, 1'b1, 1'b1, 4'b0100});
        end
    endtask

    task automatic test_all_request();
        logic [1:0] prev_sel;
        logic       prev_oe;
        logic [3:0] own;
        do_reset();
        tick(4'b1111);
        prev_sel = {select1, select0};
        prev_oe  = mux_oe;
        for (int k = 0; k < 5; k++) begin
            own = 4'(1 << (k % 4));
            for (int c = 0; c < HM; c++) begin
                tick(4'b1111);
                checks++;
                if (grant !== own || mux_oe !== 1'b1) begin
                    errors++;
                    $display("FAIL all_req_owner k=%0d c=%0d: grant %b oe %b want %b oe 1", k, c, grant, mux_oe, own);
                end
                checks++;
                if (prev_oe && {select1, select0} !== prev_sel) begin
                    errors++;
                    $display("FAIL sel_change_while_oe: sel %b prev %b", {select1, select0}, prev_sel);
                end
                if (mux_oe) begin
                    checks++;
                    if (y_tri !== y_nand) begin
                        errors++;
                        $display("FAIL mux_equiv: tri %b nand %b", y_tri, y_nand);
                    end
                end
                prev_sel = {select1, select0};
                prev_oe  = mux_oe;
            end
            if (k < 4) begin
                tick(4'b1111);
                checks++;
                if (dut_vec !== {2'((k + 1) % 4), 1'b0, 1'b1, 4'b0000}) begin
                    errors++;
                    $display("FAIL all_req_guard k=%0d: got %b want %b", k, dut_vec, {2'((k + 1) % 4), 1'b0, 1'b1, 4'b0000});
                end
                prev_sel = {select1, select0};
                prev_oe  = mux_oe;
            end
        end
    endtask

    task automatic test_lone_owner();
        do_reset();
        tick(4'b0010);
        for (int c = 0; c < 20; c++) begin
            tick(4'b0010);
            checks++;
            if (dut_vec !== {2'b01, 1'b1, 1'b1, 4'b0010}) begin
                errors++;
                $display("FAIL lone_owner c=%0d: got %b want %b", c, dut_vec, {2'b01, 1'b1, 1'b1, 4'b0010});
            end
        end
    endtask

    task automatic test_release_with_waiter();
        do_reset();
        tick(4'b0001);
        tick(4'b0001);
        tick(4'b0001);
        tick(4'b1000);
        checks++;
        if (dut_vec !== {2'b11, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL release_guard: got %b want %b", dut_vec, {2'b11, 1'b0, 1'b1, 4'b0000});
        end
        tick(4'b1000);
        checks++;
        if (grant !== 4'b1000 || mux_oe !== 1'b1) begin
            errors++;
            $display("FAIL release_grant: grant %b oe %b want 1000 oe 1", grant, mux_oe);
        end
        // Pointer lands just past the releasing owner: bit1 beats bit3.
        do_reset();
        tick(4'b0001);
        tick(4'b0001);
        tick(4'b1010);
        checks++;
        if ({select1, select0} !== 2'b01 || busy !== 1'b1 || mux_oe !== 1'b0) begin
            errors++;
            $display("FAIL rr_ptr_after_release: sel %b busy %b oe %b want sel 01 busy 1 oe 0", {select1, select0}, busy, mux_oe);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        tick(4'b0100);
        tick(4'b0100);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 9'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", dut_vec, 9'b0);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        tick(4'b0110);
        tick(4'b0110);
        checks++;
        if (grant !== 4'b0010 || mux_oe !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_rr: grant %b oe %b want 0010 oe 1", grant, mux_oe);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [1:0] prev_sel;
        logic       prev_oe;
        do_reset();
        r        = 4'b0;
        prev_sel = 2'b00;
        prev_oe  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            tick(r);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_model c=%0d req=%b: got %b want %b", c, r, dut_vec, model_vec());
            end
            checks++;
            if (prev_oe && mux_oe && {select1, select0} !== prev_sel) begin
                errors++;
                $display("FAIL random_sel_stable c=%0d: sel %b prev %b", c, {select1, select0}, prev_sel);
            end
            if (mux_oe) begin
                checks++;
                if (y_tri !== y_nand) begin
                    errors++;
                    $display("FAIL random_mux_equiv c=%0d: tri %b nand %b", c, y_tri, y_nand);
                end
            end
            prev_sel = {select1, select0};
            prev_oe  = mux_oe;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = 4'b0;
        din    = 4'b0;
        model_reset();
        test_reset();
        test_single_request();
        test_all_request();
        test_lone_owner();
        test_release_with_waiter();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
